// File: rtl/count_min_hour.sv
// count_min_hour: minute/hour timekeeping for a digital clock with a set mode.
//
// The counter runs in RUN mode, where each pulse_min tick advances the
// minute and, on wrap, the hour. btn_mode steps through the set modes, and
// btn_inc adjusts the selected field. Leaving SET_H asks the seconds
// counter to clear so the adjusted time starts on a minute boundary.
//
// State table:
//   state    | meaning
//   RUN   00 | time advances on pulse_min, btn_inc ignored
//   SET_M 01 | time frozen, btn_inc rise bumps minutes (no carry)
//   SET_H 10 | time frozen, btn_inc rise bumps hours
//   ---   11 | unreachable; recovers to RUN on the next edge
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   pulse_min  in   one-clk minute tick
//   btn_mode   in   debounced mode-button level
//   btn_inc    in   debounced increment-button level
//   cnt_m      out  current minute, 0..MIN_MOD-1
//   cnt_h      out  current hour, 0..HOUR_MOD-1
//   mode       out  current state encoding (see table)
//   pulse_day  out  one-cycle tick when 00:00 is first presented after a day rollover
//   sec_clr    out  one-cycle seconds-clear request on the SET_H -> RUN transition
module count_min_hour #(
    parameter int MIN_MOD  = 60,
    parameter int HOUR_MOD = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse_min,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] cnt_m,
    output logic [4:0] cnt_h,
    output logic [1:0] mode,
    output logic       pulse_day,
    output logic       sec_clr
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SET_M = 2'b01,
        ST_SET_H = 2'b10,
        ST_ILL   = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_m_q, cnt_m_d;
    logic [4:0] cnt_h_q, cnt_h_d;
    logic       pulse_day_q, pulse_day_d;
    logic       sec_clr_q, sec_clr_d;
    logic       mode_prev_q, mode_prev_d;
    logic       inc_prev_q, inc_prev_d;

    logic       mode_rise;
    logic       inc_rise;
    logic       m_last;
    logic       h_last;

    assign mode_rise = btn_mode & ~mode_prev_q;
    assign inc_rise  = btn_inc & ~inc_prev_q;
    assign m_last    = (cnt_m_q == 6'(MIN_MOD - 1));
    assign h_last    = (cnt_h_q == 5'(HOUR_MOD - 1));

    always_comb begin
        state_d     = state_q;
        cnt_m_d     = cnt_m_q;
        cnt_h_d     = cnt_h_q;
        pulse_day_d = 1'b0;
        sec_clr_d   = 1'b0;
        mode_prev_d = btn_mode;
        inc_prev_d  = btn_inc;

        case (state_q)
            ST_RUN: begin
                // Counting and a mode change may happen on the same edge.
                if (pulse_min) begin
                    if (m_last) begin
                        cnt_m_d = '0;
                        if (h_last) begin
                            cnt_h_d     = '0;
                            pulse_day_d = 1'b1;
                        end else begin
                            cnt_h_d = cnt_h_q + 5'd1;
                        end
                    end else begin
                        cnt_m_d = cnt_m_q + 6'd1;
                    end
                end
                if (mode_rise) begin
                    state_d = ST_SET_M;
                end
            end
            ST_SET_M: begin
                // A mode rise wins over a simultaneous increment rise.
                if (mode_rise) begin
                    state_d = ST_SET_H;
                end else if (inc_rise) begin
                    cnt_m_d = m_last ? 6'd0 : cnt_m_q + 6'd1;
                end
            end
            ST_SET_H: begin
                if (mode_rise) begin
                    state_d   = ST_RUN;
                    sec_clr_d = 1'b1;
                end else if (inc_rise) begin
                    cnt_h_d = h_last ? 5'd0 : cnt_h_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_m_q     <= '0;
            cnt_h_q     <= '0;
            pulse_day_q <= 1'b0;
            sec_clr_q   <= 1'b0;
            // Load live levels so a button held through reset is not seen as a rise.
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
        end else begin
            state_q     <= state_d;
            cnt_m_q     <= cnt_m_d;
            cnt_h_q     <= cnt_h_d;
            pulse_day_q <= pulse_day_d;
            sec_clr_q   <= sec_clr_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
        end
    end

    assign cnt_m     = cnt_m_q;
    assign cnt_h     = cnt_h_q;
    assign mode      = state_q;
    assign pulse_day = pulse_day_q;
    assign sec_clr   = sec_clr_q;

endmodule
